// File: rtl/sonic_pkg.sv
// Shared definitions for the ultrasonic ranging front end and the distance stage.
// Holds the state encoding, the echo-time width and the default sensor timing.
package sonic_pkg;

    localparam int ECHO_W = 33;
    typedef logic [ECHO_W-1:0] echo_t;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_TRIG      = 3'd1;
    localparam logic [2:0] ST_WAIT_RISE = 3'd2;
    localparam logic [2:0] ST_MEASURE   = 3'd3;
    localparam logic [2:0] ST_DONE      = 3'd4;
    localparam logic [2:0] ST_HOLDOFF   = 3'd5;

    localparam int unsigned DEF_CLKS_PER_US = 100;
    localparam int unsigned DEF_TRIG_US     = 10;
    localparam int unsigned DEF_TIMEOUT_US  = 38000;
    localparam int unsigned DEF_HOLDOFF_US  = 60000;

endpackage

// File: rtl/sonic_echo_ctrl_tick.sv
// Microsecond tick prescaler: counts 0..CLKS_PER_US-1 and ticks on the wrap.
// A restart zeroes the phase so the next tick lands a whole microsecond later.
module us_tick_gen #(
    parameter int unsigned CLKS_PER_US = 100
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int CW = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_US - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || restart) begin
            r_cnt <= '0;
        end else if (r_cnt == LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign tick = (r_cnt == LAST) && !restart;

endmodule

// File: rtl/sonic_echo_ctrl.sv
// Ultrasonic sensor front end: fires TRIG, times the ECHO high pulse in whole
// microseconds and reports it with a done pulse, then enforces sensor ring-down.
module sonic_echo_ctrl
    import sonic_pkg::*;
#(
    parameter int unsigned CLKS_PER_US = DEF_CLKS_PER_US,
    parameter int unsigned TRIG_US     = DEF_TRIG_US,
    parameter int unsigned TIMEOUT_US  = DEF_TIMEOUT_US,
    parameter int unsigned HOLDOFF_US  = DEF_HOLDOFF_US
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              echo,
    output logic              trig,
    output logic [ECHO_W-1:0] echo_time,
    output logic              e_done,
    output logic              i_idle,
    output logic              timeout,
    output logic              busy
);

    localparam longint unsigned HOLD_CYC_L = longint'(HOLDOFF_US) * longint'(CLKS_PER_US);
    localparam longint unsigned ECHO_LIM   = 64'd1 << ECHO_W;
    localparam echo_t TRIG_LAST = echo_t'(TRIG_US - 1);
    localparam echo_t TIMEOUT_V = echo_t'(TIMEOUT_US);
    localparam echo_t HOLD_LAST = echo_t'(HOLD_CYC_L - 1);

    if (CLKS_PER_US < 2 || TRIG_US < 1 || TIMEOUT_US < 1 || HOLDOFF_US < 1) begin : g_bad_timing
        $error("sonic_echo_ctrl: timing parameters out of range");
    end
    if (longint'(TIMEOUT_US) >= ECHO_LIM || HOLD_CYC_L >= ECHO_LIM) begin : g_bad_width
        $error("sonic_echo_ctrl: TIMEOUT_US or HOLDOFF_US does not fit the counters");
    end

    logic [2:0] r_state;
    logic       r_echo_s1, r_echo_s2, r_echo_d;
    logic       r_trig, r_timeout;
    echo_t      r_us_cnt, r_hold_cnt, r_echo_time;
    logic       w_rise, w_fall, w_tick, w_restart, w_start_go;
    echo_t      w_us_next;

    assign w_rise     = r_echo_s2 & ~r_echo_d;
    assign w_fall     = ~r_echo_s2 & r_echo_d;
    assign w_start_go = (r_state == ST_IDLE) && start && !rst;
    assign w_restart  = w_start_go || ((r_state == ST_WAIT_RISE) && w_rise);
    assign w_us_next  = r_us_cnt + echo_t'(1);

    us_tick_gen #(
        .CLKS_PER_US(CLKS_PER_US)
    ) u_tick (
        .clk    (clk),
        .rst    (rst),
        .restart(w_restart),
        .tick   (w_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_echo_s1 <= 1'b0;
            r_echo_s2 <= 1'b0;
            r_echo_d  <= 1'b0;
        end else begin
            r_echo_s1 <= echo;
            r_echo_s2 <= r_echo_s1;
            r_echo_d  <= r_echo_s2;
        end
    end

    // The holdoff counter measures clock cycles from the start-accept cycle and saturates.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_trig      <= 1'b0;
            r_us_cnt    <= '0;
            r_hold_cnt  <= '0;
            r_echo_time <= '0;
            r_timeout   <= 1'b0;
        end else begin
            if (r_hold_cnt != HOLD_LAST) begin
                r_hold_cnt <= r_hold_cnt + echo_t'(1);
            end
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state     <= ST_TRIG;
                        r_trig      <= 1'b1;
                        r_us_cnt    <= '0;
                        r_hold_cnt  <= echo_t'(1);
                        r_echo_time <= '0;
                        r_timeout   <= 1'b0;
                    end
                end
                ST_TRIG: begin
                    if (w_tick) begin
                        if (r_us_cnt == TRIG_LAST) begin
                            r_state  <= ST_WAIT_RISE;
                            r_trig   <= 1'b0;
                            r_us_cnt <= '0;
                        end else begin
                            r_us_cnt <= w_us_next;
                        end
                    end
                end
                ST_WAIT_RISE: begin
                    if (w_rise) begin
                        r_state  <= ST_MEASURE;
                        r_us_cnt <= '0;
                    end else if (w_tick) begin
                        if (w_us_next == TIMEOUT_V) begin
                            r_state     <= ST_DONE;
                            r_echo_time <= '0;
                            r_timeout   <= 1'b1;
                        end else begin
                            r_us_cnt <= w_us_next;
                        end
                    end
                end
                ST_MEASURE: begin
                    // A tick coinciding with the fall completes the final microsecond.
                    if (w_fall) begin
                        r_state     <= ST_DONE;
                        r_echo_time <= w_tick ? w_us_next : r_us_cnt;
                    end else if (w_tick) begin
                        if (w_us_next == TIMEOUT_V) begin
                            r_state     <= ST_DONE;
                            r_echo_time <= TIMEOUT_V;
                            r_timeout   <= 1'b1;
                        end else begin
                            r_us_cnt <= w_us_next;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_HOLDOFF;
                end
                ST_HOLDOFF: begin
                    if (r_hold_cnt == HOLD_LAST) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign trig      = r_trig;
    assign echo_time = r_echo_time;
    assign timeout   = r_timeout;
    assign e_done    = (r_state == ST_DONE);
    assign i_idle    = w_start_go;
    assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_sonic_echo_ctrl.sv
// Directed bench for sonic_echo_ctrl at 4 clk/us; timeout shortened to 1000 us to keep runs brief.
// Echo patterns are given relative to the TRIG falling edge, in clock cycles.
module tb_sonic_echo_ctrl;
    import sonic_pkg::*;

    localparam int unsigned CPU   = 4;
    localparam int unsigned T_US  = 10;
    localparam int unsigned TO_US = 1000;
    localparam int unsigned HO_US = 2000;
    localparam int HOLD_CYC = HO_US * CPU;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic echo = 1'b0;
    logic trig, e_done, i_idle, timeout, busy;
    logic [ECHO_W-1:0] echo_time;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int done_cnt = 0;
    int overlap = 0;
    int idle_q[$];

    always #5 clk = ~clk;

    sonic_echo_ctrl #(
        .CLKS_PER_US(CPU),
        .TRIG_US    (T_US),
        .TIMEOUT_US (TO_US),
        .HOLDOFF_US (HO_US)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .echo     (echo),
        .trig     (trig),
        .echo_time(echo_time),
        .e_done   (e_done),
        .i_idle   (i_idle),
        .timeout  (timeout),
        .busy     (busy)
    );

    always @(posedge clk) begin
        if (e_done) done_cnt++;
        if (i_idle) idle_q.push_back(cyc);
        if (i_idle && e_done) overlap++;
        cyc++;
    end

    typedef struct {
        logic        pre_high;  // raise echo during TRIG and hold it
        int          delay;     // cycles after TRIG fall before echo rises, -1 = never
        int          high;      // echo high cycles, -1 = stays high
        logic [32:0] exp_time;
        logic        exp_to;
        int          exp_wait;  // cycles from TRIG fall to e_done, -1 = not checked
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        start = 1'b0;
        echo = 1'b0;
        repeat (2) step();
        rst = 1'b0;
        step();
    endtask

    task automatic wait_trig_fall(input string name);
        int n;
        n = 0;
        while (!trig && n < 100) begin n++; step(); end
        n = 0;
        while (trig && n < 100) begin n++; step(); end
        if (n >= 100) chk({name, "_trig_bound"}, n, 0);
    endtask

    task automatic run_vec(input int k, input vec_t v);
        int n;
        int d0;
        d0 = done_cnt;
        start = 1'b1;
        #1;
        chk($sformatf("v%0d_i_idle", k), i_idle, 1);
        step();
        start = 1'b0;
        n = 0;
        while (trig && n < 100) begin
            n++;
            if (v.pre_high && n == 20) echo = 1'b1;
            step();
        end
        chk($sformatf("v%0d_trig_len", k), n, 40);
        if (v.delay >= 0) begin
            repeat (v.delay) step();
            echo = 1'b1;
            if (v.high >= 0) begin
                repeat (v.high) step();
                echo = 1'b0;
            end
        end
        n = 0;
        while (!e_done && n < 6000) begin n++; step(); end
        chk($sformatf("v%0d_done_seen", k), e_done, 1);
        if (v.exp_wait >= 0) chk($sformatf("v%0d_wait", k), n, v.exp_wait);
        chk($sformatf("v%0d_echo_time", k), echo_time, v.exp_time);
        chk($sformatf("v%0d_timeout", k), timeout, v.exp_to);
        chk($sformatf("v%0d_busy", k), busy, 1);
        step();
        chk($sformatf("v%0d_done_pulses", k), done_cnt - d0, 1);
        chk($sformatf("v%0d_done_low", k), e_done, 0);
        chk($sformatf("v%0d_time_held", k), echo_time, v.exp_time);
        echo = 1'b0;
    endtask

    initial begin
        int n;
        int d0;
        int base;

        vecs[0] = '{1'b0, 400, 2320, 33'd580, 1'b0, -1};   // 580 us echo after 100 us
        vecs[1] = '{1'b0, 8, 4, 33'd1, 1'b0, -1};          // exactly 1 us
        vecs[2] = '{1'b0, 40, 7, 33'd1, 1'b0, -1};         // 1.75 us truncates
        vecs[3] = '{1'b0, 40, 9, 33'd2, 1'b0, -1};         // 2.25 us truncates
        vecs[4] = '{1'b0, -1, 0, 33'd0, 1'b1, 4000};       // no echo at all
        vecs[5] = '{1'b0, 100, -1, 33'd1000, 1'b1, -1};    // echo stuck high
        vecs[6] = '{1'b1, -1, 0, 33'd0, 1'b1, 4000};       // echo already high at WAIT_RISE
        vecs[7] = '{1'b0, 0, 3999, 33'd999, 1'b0, -1};     // just under timeout
        vecs[8] = '{1'b0, 0, 4001, 33'd1000, 1'b1, -1};    // just over timeout

        // Reset state, with start and echo active during reset
        rst = 1'b1;
        start = 1'b1;
        echo = 1'b1;
        repeat (3) step();
        chk("rst_trig", trig, 0);
        chk("rst_busy", busy, 0);
        chk("rst_e_done", e_done, 0);
        chk("rst_i_idle", i_idle, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_echo_time", echo_time, 0);
        start = 1'b0;
        echo = 1'b0;
        rst = 1'b0;
        repeat (5) step();

        // Echo glitch while idle
        d0 = done_cnt;
        echo = 1'b1;
        repeat (10) step();
        echo = 1'b0;
        repeat (10) step();
        chk("idle_glitch_busy", busy, 0);
        chk("idle_glitch_done", done_cnt - d0, 0);

        // Echo fall to e_done latency: 50-cycle echo gives 12 us
        start = 1'b1;
        step();
        start = 1'b0;
        wait_trig_fall("lat");
        echo = 1'b1;
        repeat (50) step();
        echo = 1'b0;
        step();
        step();
        chk("lat_e2", e_done, 0);
        step();
        chk("lat_e3", e_done, 1);
        chk("lat_echo_time", echo_time, 12);
        step();

        // Reset during HOLDOFF clears the held result
        rst = 1'b1;
        step();
        chk("rst_hold_echo_time", echo_time, 0);
        chk("rst_hold_busy", busy, 0);
        rst = 1'b0;
        step();

        // Reset during TRIG drops trig at that edge
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (5) step();
        chk("trig_mid", trig, 1);
        rst = 1'b1;
        step();
        chk("rst_trig_mid", trig, 0);
        chk("rst_trig_busy", busy, 0);
        rst = 1'b0;
        step();

        // Reset mid-MEASURE: no e_done afterwards
        d0 = done_cnt;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_trig_fall("rstm");
        echo = 1'b1;
        repeat (200) step();
        chk("meas_busy", busy, 1);
        rst = 1'b1;
        step();
        chk("rstm_busy", busy, 0);
        chk("rstm_trig", trig, 0);
        chk("rstm_e_done", e_done, 0);
        chk("rstm_timeout", timeout, 0);
        rst = 1'b0;
        echo = 1'b0;
        repeat (20) step();
        chk("rstm_no_done", done_cnt - d0, 0);
        chk("rstm_idle", busy, 0);

        // Table of full measurements, each from a fresh reset
        for (int k = 0; k < 9; k++) begin
            do_reset();
            run_vec(k, vecs[k]);
        end

        // Start held high: i_idle every HOLDOFF, start in MEASURE ignored
        do_reset();
        base = idle_q.size();
        d0 = done_cnt;
        start = 1'b1;
        wait_trig_fall("held");
        echo = 1'b1;
        repeat (400) step();
        echo = 1'b0;
        n = 0;
        while (idle_q.size() < base + 3 && n < 20000) begin n++; step(); end
        start = 1'b0;
        chk("held_idle_count", idle_q.size() - base, 3);
        if (idle_q.size() >= base + 3) begin
            chk("held_spacing1", idle_q[base + 1] - idle_q[base], HOLD_CYC);
            chk("held_spacing2", idle_q[base + 2] - idle_q[base + 1], HOLD_CYC);
        end
        chk("held_done_count", done_cnt - d0, 2);
        do_reset();

        chk("idle_done_overlap", overlap, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
